// File: rtl/serializer_stream_if.sv
// serializer_stream_if
//   Bundles the parallel-word input and the serial output of serializer_stream.
//   data / data_mod / data_val : parallel word, bit count (0 = DATA_W), strobe
//   ser_data / ser_data_val    : serial bit and its qualifier
//   busy                       : high while new words are not accepted
//   master: the parallel source / serial sink side; slave: the serializer.
interface serializer_stream_if #(
    parameter int DATA_W = 16
);
    localparam int MOD_W = $clog2(DATA_W);

    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  data_mod;
    logic              data_val;
    logic              ser_data;
    logic              ser_data_val;
    logic              busy;

    modport master (
        output data, data_mod, data_val,
        input  ser_data, ser_data_val, busy
    );

    modport slave (
        input  data, data_mod, data_val,
        output ser_data, ser_data_val, busy
    );
endinterface

// File: rtl/serializer_stream.sv
// serializer_stream
//   Gapless parallel-to-serial converter. A word accepted on data_val && !busy
//   is emitted one bit per clock, MSB- or LSB-first, for L = data_mod (0 = DATA_W)
//   cycles. Words shorter than MIN_LEN are dropped. A word strobed during the
//   last bit cycle follows with no idle cycle.
//   Ports:
//     clk_i    : clock, rising edge
//     srst_n_i : synchronous reset, active low
//     bus      : serializer_stream_if.slave (data/data_mod/data_val in,
//                ser_data/ser_data_val/busy out, all outputs registered)
//   Optional build macro SERIALIZER_STREAM_PARITY_EN: appends one even-parity
//   bit after the data bits and holds busy through the last data bit.
module serializer_stream #(
    parameter int DATA_W    = 16,
    parameter int MSB_FIRST = 1,
    parameter int MIN_LEN   = 3
) (
    input  logic                clk_i,
    input  logic                srst_n_i,
    serializer_stream_if.slave  bus
);
    localparam int MOD_W = $clog2(DATA_W);
    localparam int CNT_W = MOD_W + 1;
    localparam logic [CNT_W-1:0] DATA_L = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);

`ifdef SERIALIZER_STREAM_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] sreg, sreg_n;   // bits not yet emitted, next bit at the head
    logic [CNT_W-1:0]  cnt, cnt_n;     // bits left including the one on the output
    logic              ser_q, ser_n;
    logic              val_q, val_n;
    logic              busy_q, busy_n;
`ifdef SERIALIZER_STREAM_PARITY_EN
    logic              par, par_n;     // XOR of bits emitted so far
`endif

    logic [CNT_W-1:0]  len;
    logic              load;
    logic              head_in, head_sr;
    logic [DATA_W-1:0] rest_in, rest_sr;

    always_comb begin
        len     = (bus.data_mod == '0) ? DATA_L : {1'b0, bus.data_mod};
        // busy_q is low in the last bit cycle, which is what makes chaining gapless
        load    = bus.data_val && !busy_q && (len >= MIN_L);
        head_in = (MSB_FIRST != 0) ? bus.data[DATA_W-1] : bus.data[0];
        rest_in = (MSB_FIRST != 0) ? (bus.data << 1) : (bus.data >> 1);
        head_sr = (MSB_FIRST != 0) ? sreg[DATA_W-1] : sreg[0];
        rest_sr = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        ser_n   = 1'b0;
        val_n   = 1'b0;
        busy_n  = 1'b0;
`ifdef SERIALIZER_STREAM_PARITY_EN
        par_n   = par;
`endif
        if ((state != SHIFT) || (cnt <= ONE)) begin
            // Output slot frees up next cycle: either start a new word or idle.
`ifdef SERIALIZER_STREAM_PARITY_EN
            if (state == SHIFT) begin
                state_n = PARITY;
                ser_n   = par;
                val_n   = 1'b1;
            end else
`endif
            if (load) begin
                state_n = SHIFT;
                sreg_n  = rest_in;
                cnt_n   = len;
                ser_n   = head_in;
                val_n   = 1'b1;
`ifdef SERIALIZER_STREAM_PARITY_EN
                busy_n  = 1'b1;
                par_n   = head_in;
`else
                busy_n  = (len > ONE);
`endif
            end else begin
                state_n = IDLE;
            end
        end else begin
            sreg_n = rest_sr;
            cnt_n  = cnt - ONE;
            ser_n  = head_sr;
            val_n  = 1'b1;
`ifdef SERIALIZER_STREAM_PARITY_EN
            busy_n = 1'b1;
            par_n  = par ^ head_sr;
`else
            busy_n = (cnt > TWO);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            ser_q  <= 1'b0;
            val_q  <= 1'b0;
            busy_q <= 1'b0;
`ifdef SERIALIZER_STREAM_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            cnt    <= cnt_n;
            ser_q  <= ser_n;
            val_q  <= val_n;
            busy_q <= busy_n;
`ifdef SERIALIZER_STREAM_PARITY_EN
            par    <= par_n;
`endif
        end
    end

    assign bus.ser_data     = ser_q;
    assign bus.ser_data_val = val_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream
//   Drives an MSB-first and an LSB-first serializer_stream with identical
//   stimulus and compares both against a queue-based reference: each accepted
//   word pushes its selected bits (plus parity in the parity build) onto a
//   queue, one entry leaves per clock, and busy means entries remain after the
//   current one.
module tb_serializer_stream;
    localparam int DW      = 16;
    localparam int MIN_LEN = 3;
`ifdef SERIALIZER_STREAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk    = 1'b0;
    logic srst_n = 1'b0;

    serializer_stream_if #(.DATA_W(DW)) if_m ();
    serializer_stream_if #(.DATA_W(DW)) if_l ();

    serializer_stream #(.DATA_W(DW), .MSB_FIRST(1), .MIN_LEN(MIN_LEN)) dut_m (
        .clk_i(clk), .srst_n_i(srst_n), .bus(if_m.slave)
    );
    serializer_stream #(.DATA_W(DW), .MSB_FIRST(0), .MIN_LEN(MIN_LEN)) dut_l (
        .clk_i(clk), .srst_n_i(srst_n), .bus(if_l.slave)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   qm[$];
    bit   ql[$];
    logic em_bit = 1'b0, el_bit = 1'b0, e_val = 1'b0, e_busy = 1'b0;

    function automatic logic [5:0] obs();
        return {if_m.ser_data, if_m.ser_data_val, if_m.busy,
                if_l.ser_data, if_l.ser_data_val, if_l.busy};
    endfunction

    function automatic logic [5:0] expv();
        return {em_bit, e_val, e_busy, el_bit, e_val, e_busy};
    endfunction

    // One clock: drive inputs, advance the reference at the edge, return at negedge.
    task automatic tick(input logic rst_n, input logic v,
                        input logic [DW-1:0] d, input logic [3:0] m);
        int len;
        bit pm, pl;
        srst_n        = rst_n;
        if_m.data     = d;  if_l.data     = d;
        if_m.data_mod = m;  if_l.data_mod = m;
        if_m.data_val = v;  if_l.data_val = v;
        @(posedge clk);
        len = (m == 4'd0) ? DW : int'(m);
        if (!rst_n) begin
            qm.delete();
            ql.delete();
        end else if (v && !e_busy && len >= MIN_LEN) begin
            pm = 1'b0;
            pl = 1'b0;
            for (int k = 0; k < len; k++) begin
                qm.push_back(d[DW-1-k]);
                ql.push_back(d[k]);
                pm ^= d[DW-1-k];
                pl ^= d[k];
            end
            if (PAR != 0) begin
                qm.push_back(pm);
                ql.push_back(pl);
            end
        end
        if (qm.size() > 0) begin
            em_bit = qm.pop_front();
            el_bit = ql.pop_front();
            e_val  = 1'b1;
        end else begin
            em_bit = 1'b0;
            el_bit = 1'b0;
            e_val  = 1'b0;
        end
        e_busy = (qm.size() > 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b1, 16'hFFFF, 4'd0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL reset c%0d: got %b want %b", c, obs(), expv());
            end
        end
    endtask

    task automatic test_full_word();
        logic [DW-1:0] word = '0;
        int nv = 0, nb = 0;
        for (int c = 0; c < 19; c++) begin
            if (c == 0) tick(1'b1, 1'b1, 16'hA5C3, 4'd0);
            else        tick(1'b1, 1'b0, 16'h0000, 4'd0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL full_word c%0d: got %b want %b", c, obs(), expv());
            end
            if (if_m.ser_data_val === 1'b1) begin
                if (nv < DW) word = {word[DW-2:0], if_m.ser_data};
                nv++;
            end
            if (if_m.busy === 1'b1) nb++;
        end
        total++;
        if (word !== 16'hA5C3) begin
            bad++;
            $display("FAIL full_word_bits: got %h want a5c3", word);
        end
        total++;
        if (nv != DW + PAR || nb != DW - 1 + PAR) begin
            bad++;
            $display("FAIL full_word_counts: got val=%0d busy=%0d want val=%0d busy=%0d",
                     nv, nb, DW + PAR, DW - 1 + PAR);
        end
    endtask

    task automatic test_partial();
        int nv = 0, ones_m = 0, ones_l = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) tick(1'b1, 1'b1, 16'hF800, 4'd5);
            else        tick(1'b1, 1'b0, 16'h0000, 4'd0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL partial c%0d: got %b want %b", c, obs(), expv());
            end
            if (if_m.ser_data_val === 1'b1 && nv < 5) begin
                ones_m += int'(if_m.ser_data);
                ones_l += int'(if_l.ser_data);
                nv++;
            end
        end
        total++;
        if (ones_m != 5 || ones_l != 0 || nv != 5) begin
            bad++;
            $display("FAIL partial_bits: got msb=%0d lsb=%0d n=%0d want 5 0 5", ones_m, ones_l, nv);
        end
    endtask

    task automatic test_min_len();
        int nv = 0, nb_drop = 0;
        for (int c = 0; c < 14; c++) begin
            case (c)
                0:       tick(1'b1, 1'b1, 16'hFFFF, 4'd1);
                3:       tick(1'b1, 1'b1, 16'hFFFF, 4'd2);
                6:       tick(1'b1, 1'b1, 16'hE007, 4'd3);
                default: tick(1'b1, 1'b0, 16'h0000, 4'd0);
            endcase
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL min_len c%0d: got %b want %b", c, obs(), expv());
            end
            if (if_m.ser_data_val === 1'b1) nv++;
            if (c < 6 && (if_m.busy !== 1'b0 || if_m.ser_data_val !== 1'b0)) nb_drop++;
        end
        total++;
        if (nv != 3 + PAR || nb_drop != 0) begin
            bad++;
            $display("FAIL min_len_counts: got val=%0d drop_activity=%0d want %0d 0", nv, nb_drop, 3 + PAR);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = '0;
        int nv = 0, first = -1, last = -1;
        for (int c = 0; c < 14; c++) begin
            case (c)
                0:       tick(1'b1, 1'b1, 16'h9009, 4'd4);
                2:       tick(1'b1, 1'b1, 16'hFFFF, 4'd0);
                4:       tick(1'b1, 1'b1, 16'h6006, 4'd4);
                default: tick(1'b1, 1'b0, 16'h0000, 4'd0);
            endcase
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL back_to_back c%0d: got %b want %b", c, obs(), expv());
            end
            if (if_m.ser_data_val === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                if (nv < 8) bits = {bits[6:0], if_m.ser_data};
                nv++;
            end
        end
`ifndef SERIALIZER_STREAM_PARITY_EN
        total++;
        if (bits !== 8'b1001_0110 || nv != 8 || last - first != 7) begin
            bad++;
            $display("FAIL back_to_back_stream: got bits=%b n=%0d span=%0d want 10010110 8 7",
                     bits, nv, last - first);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] word = '0;
        int nv = 0;
        tick(1'b1, 1'b1, 16'h3C5A, 4'd0);
        for (int c = 0; c < 5; c++) tick(1'b1, 1'b0, 16'h0000, 4'd0);
        tick(1'b0, 1'b1, 16'hFFFF, 4'd0);
        total++;
        if (if_m.ser_data_val !== 1'b0 || if_m.busy !== 1'b0 || obs() !== expv()) begin
            bad++;
            $display("FAIL reset_mid: got %b want %b", obs(), expv());
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 1) tick(1'b1, 1'b1, 16'h8001, 4'd0);
            else        tick(1'b1, 1'b0, 16'h0000, 4'd0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL reset_mid_after c%0d: got %b want %b", c, obs(), expv());
            end
            if (if_m.ser_data_val === 1'b1) begin
                if (nv < DW) word = {word[DW-2:0], if_m.ser_data};
                nv++;
            end
        end
        total++;
        if (word !== 16'h8001 || nv != DW + PAR) begin
            bad++;
            $display("FAIL reset_mid_word: got %h n=%0d want 8001 %0d", word, nv, DW + PAR);
        end
    endtask

`ifdef SERIALIZER_STREAM_PARITY_EN
    task automatic test_parity();
        logic [3:0] b1 = '0, b2 = '0;
        int n1 = 0, n2 = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0)      tick(1'b1, 1'b1, 16'hA005, 4'd3);
            else if (c == 5) tick(1'b1, 1'b1, 16'hE007, 4'd3);
            else             tick(1'b1, 1'b0, 16'h0000, 4'd0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL parity c%0d: got %b want %b", c, obs(), expv());
            end
            if (if_m.ser_data_val === 1'b1) begin
                if (c < 5) begin b1 = {b1[2:0], if_m.ser_data}; n1++; end
                else       begin b2 = {b2[2:0], if_m.ser_data}; n2++; end
            end
        end
        total++;
        if (b1 !== 4'b1010 || b2 !== 4'b1111 || n1 != 4 || n2 != 4) begin
            bad++;
            $display("FAIL parity_bits: got %b/%0d %b/%0d want 1010/4 1111/4", b1, n1, b2, n2);
        end
    endtask
`endif

    task automatic test_random();
        logic          rst_n, v;
        logic [DW-1:0] d;
        logic [3:0]    m;
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            v     = ($urandom_range(0, 3) != 0);
            d     = DW'($urandom);
            m     = 4'($urandom_range(0, 15));
            tick(rst_n, v, d, m);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random c%0d: got %b want %b", c, obs(), expv());
            end
        end
    endtask

    initial begin
        if_m.data = '0; if_m.data_mod = '0; if_m.data_val = 1'b0;
        if_l.data = '0; if_l.data_mod = '0; if_l.data_val = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_partial();
        test_min_len();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIALIZER_STREAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
